snac_serial_poller: RTL

- Sequences the SNAC cartridge-port controller link for the Pocket Analogizer input path.
- Periodically generates the latch/clock waveform for shift-register pads (NeoGeo/SNES-style DB15 adapters) and deserialises two player data lines.
- Publishes active-high button words to the snac_p1/snac_p2 mapping logic, with a one-cycle valid strobe.
- Sits between the cart_tran pad drivers and the core's player-input remapping.

---
 rtl/snac_serial_poller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/snac_serial_poller.sv
// SNAC shift-register pad poller: latch/clock sequencing and two-player
// deserialisation into active-high button words with a one-cycle strobe.
module snac_serial_poller #(
   parameter int CLK_DIV     = 4,
   parameter int NUM_BITS    = 16,
   parameter int POLL_PERIOD = 48000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ena,
   input  logic        i_dat1,
   input  logic        i_dat2,
   output logic        o_latch,
   output logic        o_clk,
   output logic [15:0] o_p1_btn,
   output logic [15:0] o_p2_btn,
   output logic        o_valid,
   output logic        o_busy
);

   localparam int CW = $clog2(POLL_PERIOD + 1);
   localparam int PW = $clog2(2 * CLK_DIV + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(POLL_PERIOD - 1);
   localparam logic [PW-1:0] LAT_LAST = PW'(2 * CLK_DIV - 1);
   localparam logic [PW-1:0] BIT_LAST = PW'(CLK_DIV - 1);
   localparam logic [3:0]    IDX_LAST = 4'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      BIT_LO,
      BIT_HI,
      DONE
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [PW-1:0] ph, ph_n;
   logic [3:0]    idx, idx_n;
   logic [15:0]   sh1, sh1_n;
   logic [15:0]   sh2, sh2_n;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ph       <= '0;
         idx      <= '0;
         sh1      <= '0;
         sh2      <= '0;
         o_latch  <= 1'b0;
         o_clk    <= 1'b1;
         o_p1_btn <= '0;
         o_p2_btn <= '0;
         o_valid  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ph      <= ph_n;
         idx     <= idx_n;
         sh1     <= sh1_n;
         sh2     <= sh2_n;
         // Pad outputs are decoded from the next state so they align with it
         o_latch <= (state_n == LATCH);
         o_clk   <= (state_n != BIT_LO);
         o_valid <= (state_n == DONE);
         if (state_n == DONE) begin
            o_p1_btn <= sh1_n;
            o_p2_btn <= sh2_n;
         end
      end
   end

   assign o_busy = (state != IDLE);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ph_n    = ph + 1'b1;
      idx_n   = idx;
      sh1_n   = sh1;
      sh2_n   = sh2;
      unique case (state)
         IDLE: begin
            ph_n = '0;
            if (!i_ena) begin
               cnt_n = '0;
            end else if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               state_n = LATCH;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         LATCH: begin
            if (ph == LAT_LAST) begin
               ph_n    = '0;
               idx_n   = '0;
               sh1_n   = '0;
               sh2_n   = '0;
               state_n = BIT_LO;
            end
         end
         BIT_LO: begin
            if (ph == BIT_LAST) begin
               ph_n       = '0;
               sh1_n[idx] = ~i_dat1;
               sh2_n[idx] = ~i_dat2;
               state_n    = BIT_HI;
            end
         end
         BIT_HI: begin
            if (ph == BIT_LAST) begin
               ph_n = '0;
               if (idx == IDX_LAST) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx + 1'b1;
                  state_n = BIT_LO;
               end
            end
         end
         DONE: begin
            ph_n    = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            ph_n    = '0;
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

endmodule
